midi_message_parser: RTL and testbench

Sits between the MIDI UART receiver and the note/control dispatch logic. Consumes raw received bytes and assembles complete channel-voice messages of type MIDI::message_t. Handles running status, realtime bytes, SysEx discard and optional channel filtering, and emits one valid pulse per complete message.

---
 rtl/midi_message_parser.sv | 174 +++++++++++++++++
 tb/tb_midi_message_parser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_message_parser.sv
// MIDI channel-voice message parser.
// Turns a stream of received MIDI bytes into complete channel-voice messages,
// tracking running status, ignoring realtime bytes, discarding SysEx payloads
// and optionally dropping messages addressed to other channels.
//
// Byte handshake: byte_valid is a one-cycle strobe and byte_data is sampled
// only in cycles where byte_valid is high; there is no back-pressure, so a
// byte may be presented every cycle. message_valid and parse_error are
// one-cycle pulses; message and message_channel hold their values between
// completions.

package MIDI;
  localparam int CHANNEL_WIDTH = 4;
  localparam int DATA_WIDTH    = 7;

  // Value of bit 7 of a MIDI byte.
  localparam logic STATUS = 1'b1;
  localparam logic DATA   = 1'b0;

  typedef enum logic [3:0] {
    NOTE_OFF         = 4'h8,
    NOTE_ON          = 4'h9,
    POLY_PRESSURE    = 4'hA,
    CONTROL_CHANGE   = 4'hB,
    PROGRAM_CHANGE   = 4'hC,
    CHANNEL_PRESSURE = 4'hD,
    PITCH_BEND       = 4'hE
  } message_type_t;

  typedef struct packed {
    message_type_t         message_type;
    logic [DATA_WIDTH-1:0] data_byte1;
    logic [DATA_WIDTH-1:0] data_byte2;
  } message_t;
endpackage

module midi_message_parser #(
  parameter bit                             CHANNEL_FILTER_EN = 1'b0,
  parameter logic [MIDI::CHANNEL_WIDTH-1:0] CHANNEL           = 4'd0
) (
  input  logic                            clock,
  input  logic                            reset_l,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  output logic                            message_valid,
  output MIDI::message_t                  message,
  output logic [MIDI::CHANNEL_WIDTH-1:0]  message_channel,
  output logic                            parse_error,
  output logic [1:0]                      debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_t;

  state_t                          state, state_next;
  logic [3:0]                      rs_type, rs_type_next;
  logic [MIDI::CHANNEL_WIDTH-1:0]  rs_channel, rs_channel_next;
  logic [MIDI::DATA_WIDTH-1:0]     data1, data1_next;
  // Set while in WAIT_D1 after a new status byte, before any data arrived.
  logic                            fresh, fresh_next;

  logic                            complete;
  logic                            error_next;
  MIDI::message_t                  msg_next;

  logic is_status;
  logic is_realtime;
  logic is_voice;
  logic is_sysex_start;
  logic truncating;
  logic one_byte;
  logic channel_match;

  assign is_status      = (byte_data[7] == MIDI::STATUS);
  assign is_realtime    = (byte_data[7:3] == 5'b11111);
  assign is_voice       = is_status && (byte_data[7:4] != 4'hF);
  assign is_sysex_start = (byte_data == 8'hF0);
  // Any non-realtime status (F0 included) arriving here abandons a message.
  assign truncating     = (state == WAIT_D2) || ((state == WAIT_D1) && fresh);
  assign one_byte       = (rs_type == 4'hC) || (rs_type == 4'hD);
  assign channel_match  = !CHANNEL_FILTER_EN || (rs_channel == CHANNEL);
  assign debug_state    = state;

  // Next-state, running-status and message assembly logic.
  always_comb begin
    state_next      = state;
    rs_type_next    = rs_type;
    rs_channel_next = rs_channel;
    data1_next      = data1;
    fresh_next      = fresh;
    complete        = 1'b0;
    error_next      = 1'b0;
    msg_next        = '0;

    if (byte_valid && !is_realtime) begin
      if (is_voice) begin
        rs_type_next    = byte_data[7:4];
        rs_channel_next = byte_data[3:0];
        state_next      = WAIT_D1;
        fresh_next      = 1'b1;
        error_next      = truncating;
      end else if (is_status) begin
        rs_type_next    = '0;
        rs_channel_next = '0;
        fresh_next      = 1'b0;
        error_next      = truncating;
        state_next      = is_sysex_start ? SYSEX : IDLE;
      end else begin
        case (state)
          WAIT_D1: begin
            fresh_next = 1'b0;
            if (one_byte) begin
              complete            = 1'b1;
              msg_next.data_byte1 = byte_data[6:0];
            end else begin
              data1_next = byte_data[6:0];
              state_next = WAIT_D2;
            end
          end
          WAIT_D2: begin
            complete            = 1'b1;
            msg_next.data_byte1 = data1;
            msg_next.data_byte2 = byte_data[6:0];
            state_next          = WAIT_D1;
          end
          default: ;
        endcase
      end
    end

    // Note-on with zero velocity is reported as note-off.
    msg_next.message_type = ((rs_type == 4'h9) && (msg_next.data_byte2 == '0)) ?
                            MIDI::NOTE_OFF : MIDI::message_type_t'(rs_type);
  end

  // State and running-status registers.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      rs_type    <= '0;
      rs_channel <= '0;
      data1      <= '0;
      fresh      <= 1'b0;
    end else begin
      state      <= state_next;
      rs_type    <= rs_type_next;
      rs_channel <= rs_channel_next;
      data1      <= data1_next;
      fresh      <= fresh_next;
    end
  end

  // Registered outputs: pulses plus held message of the last accepted completion.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      message_valid   <= 1'b0;
      parse_error     <= 1'b0;
      message         <= '0;
      message_channel <= '0;
    end else begin
      message_valid <= complete && channel_match;
      parse_error   <= error_next;
      if (complete && channel_match) begin
        message         <= msg_next;
        message_channel <= rs_channel;
      end
    end
  end

endmodule

// File: tb/tb_midi_message_parser.sv
// Testbench for midi_message_parser: directed vector table, hand sequences for
// reset and channel filtering, then random bytes against a reference model.
module tb_midi_message_parser;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_l;
  logic       byte_valid;
  logic [7:0] byte_data;

  always #5 clock = ~clock;

  logic           mv0, pe0, mv1, pe1;
  MIDI::message_t msg0, msg1;
  logic [3:0]     ch0, ch1;
  logic [1:0]     ds0, ds1;

  // Omni instance.
  midi_message_parser #(.CHANNEL_FILTER_EN(1'b0), .CHANNEL(4'd0)) dut0 (
    .clock(clock), .reset_l(reset_l), .byte_valid(byte_valid), .byte_data(byte_data),
    .message_valid(mv0), .message(msg0), .message_channel(ch0),
    .parse_error(pe0), .debug_state(ds0)
  );

  // Filtered instance, accepting channel 2 only.
  midi_message_parser #(.CHANNEL_FILTER_EN(1'b1), .CHANNEL(4'd2)) dut1 (
    .clock(clock), .reset_l(reset_l), .byte_valid(byte_valid), .byte_data(byte_data),
    .message_valid(mv1), .message(msg1), .message_channel(ch1),
    .parse_error(pe1), .debug_state(ds1)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [17:0] mk(input logic [3:0] t, input logic [6:0] a, input logic [6:0] b);
    return {t, a, b};
  endfunction

  // ---------------- reference model ----------------
  logic       m_have_rs;
  logic [3:0] m_type;
  logic [3:0] m_ch;
  logic [6:0] m_pend[$];
  logic       m_fresh;
  logic       e_v[2];
  logic [17:0] e_m[2];
  logic [3:0] e_c[2];
  logic       e_err;

  task automatic model_reset();
    m_have_rs = 1'b0; m_type = '0; m_ch = '0; m_fresh = 1'b0;
    m_pend.delete();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      e_v[k] = 1'b0; e_m[k] = '0; e_c[k] = '0;
    end
    e_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int need;
    logic [6:0] d1, d2;
    logic [3:0] t;
    e_v[0] = 1'b0; e_v[1] = 1'b0; e_err = 1'b0;
    if (!v || b >= 8'hF8) return;
    if (b[7]) begin
      e_err = m_have_rs && (m_pend.size() > 0 || m_fresh);
      m_pend.delete();
      if (b < 8'hF0) begin
        m_have_rs = 1'b1; m_type = b[7:4]; m_ch = b[3:0]; m_fresh = 1'b1;
      end else begin
        m_have_rs = 1'b0; m_fresh = 1'b0;
      end
    end else if (m_have_rs) begin
      m_pend.push_back(b[6:0]);
      m_fresh = 1'b0;
      need = (m_type == 4'hC || m_type == 4'hD) ? 1 : 2;
      if (m_pend.size() == need) begin
        d1 = m_pend[0];
        d2 = (need == 2) ? m_pend[1] : 7'd0;
        t  = (m_type == 4'h9 && d2 == 7'd0) ? 4'h8 : m_type;
        for (int k = 0; k < 2; k++) begin
          if (k == 0 || m_ch == 4'd2) begin
            e_v[k] = 1'b1; e_m[k] = mk(t, d1, d2); e_c[k] = m_ch;
          end
        end
        exp_q.push_back({m_ch, mk(t, d1, d2)});
        m_pend.delete();
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clock);
    byte_valid = v;
    byte_data  = b;
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_l    = 1'b0;
    byte_valid = 1'b0;
    model_reset();
    @(negedge clock);
    reset_l = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        ev;
    logic [17:0] em;
    logic [3:0]  ec;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] b, input logic ev,
                     input logic [17:0] em, input logic [3:0] ec, input logic ee);
    vec_t x;
    x.v = v; x.b = b; x.ev = ev; x.em = em; x.ec = ec; x.ee = ee;
    tbl.push_back(x);
  endtask

  task automatic add_b(input logic [7:0] b);
    add(1'b1, b, 1'b0, '0, '0, 1'b0);
  endtask

  logic [17:0] last_m;
  logic [3:0]  last_c;

  initial begin
    reset_l    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_reset();

    // Note on, running status with velocity-0 conversion.
    add_b(8'h90); add_b(8'h3C); add(1, 8'h64, 1, mk(4'h9, 7'h3C, 7'h64), 4'h0, 0);
    add_b(8'h93); add_b(8'h40); add(1, 8'h7F, 1, mk(4'h9, 7'h40, 7'h7F), 4'h3, 0);
    add_b(8'h41); add(1, 8'h00, 1, mk(4'h8, 7'h41, 7'h00), 4'h3, 0);
    // One-byte type with realtime in between.
    add_b(8'hC5); add_b(8'hF8); add(1, 8'h07, 1, mk(4'hC, 7'h07, 7'h00), 4'h5, 0);
    // Truncation of a 2-byte message.
    add_b(8'hB0); add_b(8'h15); add(1, 8'h90, 0, '0, '0, 1);
    add_b(8'h3C); add(1, 8'h40, 1, mk(4'h9, 7'h3C, 7'h40), 4'h0, 0);
    // SysEx and stray data.
    add_b(8'hF0); add_b(8'h01); add_b(8'h02); add_b(8'hF7); add_b(8'h10);
    add_b(8'hB0); add_b(8'h16); add(1, 8'h20, 1, mk(4'hB, 7'h16, 7'h20), 4'h0, 0);
    // Fresh status replaced by another status.
    add_b(8'h90); add(1, 8'h80, 0, '0, '0, 1);
    add_b(8'h3C); add(1, 8'h00, 1, mk(4'h8, 7'h3C, 7'h00), 4'h0, 0);
    // System common after completion: no error; stray data in idle.
    add_b(8'hF6); add_b(8'h05);
    add_b(8'hE7); add_b(8'h01); add(1, 8'h02, 1, mk(4'hE, 7'h01, 7'h02), 4'h7, 0);
    add_b(8'hE7); add_b(8'h01); add(1, 8'hF3, 0, '0, '0, 1);
    // Idle gap inside a message.
    add_b(8'hD9); add(0, 8'h55, 0, '0, '0, 0);
    add(1, 8'h7F, 1, mk(4'hD, 7'h7F, 7'h00), 4'h9, 0);
    add_b(8'h9F); add_b(8'h3C); add(1, 8'h00, 1, mk(4'h8, 7'h3C, 7'h00), 4'hF, 0);
    // System common truncating a fresh status.
    add_b(8'hA4); add(1, 8'hF2, 0, '0, '0, 1); add_b(8'h55);

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_valid0", mv0, 0); check("rst_err0", pe0, 0);
    check("rst_msg0", msg0, 0);  check("rst_ch0", ch0, 0);
    check("rst_valid1", mv1, 0); check("rst_err1", pe1, 0);
    check("rst_msg1", msg1, 0);  check("rst_ch1", ch1, 0);
    reset_l = 1'b1;

    // Directed table on the omni instance.
    last_m = '0;
    last_c = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].b);
      check($sformatf("tbl%0d_valid", i), mv0, tbl[i].ev);
      check($sformatf("tbl%0d_err", i), pe0, tbl[i].ee);
      if (tbl[i].ev) begin
        last_m = tbl[i].em;
        last_c = tbl[i].ec;
      end
      check($sformatf("tbl%0d_msg", i), msg0, last_m);
      check($sformatf("tbl%0d_ch", i), ch0, last_c);
    end

    // Reset in the middle of a message.
    do_reset();
    drive(1, 8'h90);
    drive(1, 8'h3C);
    @(negedge clock); reset_l = 1'b0;
    @(negedge clock); reset_l = 1'b1;
    drive(1, 8'h40);
    check("midrst_valid", mv0, 0);
    check("midrst_msg", msg0, 0);
    drive(1, 8'h3C);
    check("midrst_nors_a", mv0, 0);
    drive(1, 8'h40);
    check("midrst_nors_b", mv0, 0);

    // Channel filter.
    do_reset();
    drive(1, 8'h91); drive(1, 8'h3C); drive(1, 8'h40);
    check("filt_omni_valid", mv0, 1);
    check("filt_other_valid", mv1, 0);
    check("filt_other_msg", msg1, 0);
    drive(1, 8'h92); drive(1, 8'h3C);
    check("filt_mid_valid", mv1, 0);
    drive(1, 8'h40);
    check("filt_match_valid", mv1, 1);
    check("filt_match_msg", msg1, mk(4'h9, 7'h3C, 7'h40));
    check("filt_match_ch", ch1, 2);
    drive(0, 8'h00);
    check("filt_pulse_end", mv1, 0);

    // Random stimulus against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       v;
      logic [7:0] b;
      int         r;
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(0, 127));
      else if (r < 82) begin
        b[7:4] = 4'($urandom_range(8, 14));
        b[3:0] = ($urandom_range(0, 2) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      end
      else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 96) b = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF7;
      else             b = 8'($urandom_range(8'hF1, 8'hF6));
      model_step(v, b);
      drive(v, b);
      check("rnd_valid0", mv0, e_v[0]);
      check("rnd_valid1", mv1, e_v[1]);
      check("rnd_err0", pe0, e_err);
      check("rnd_err1", pe1, e_err);
      check("rnd_msg0", msg0, e_m[0]);
      check("rnd_msg1", msg1, e_m[1]);
      check("rnd_ch0", ch0, e_c[0]);
      check("rnd_ch1", ch1, e_c[1]);
      if (mv0) begin
        if (exp_q.size() > 0) check("sb_msg", {ch0, msg0}, exp_q.pop_front());
        else check("sb_extra_msg", exp_q.size(), 1);
      end
    end
    check("sb_leftover", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
